// File: rtl/control_pkg.sv
// Shared encodings for the ARM-subset control unit: op/cmd fields, ALU and
// immediate selects, condition codes and the memory-wait FSM state.
package control_pkg;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_8   = 2'b00;
    localparam logic [1:0] IMM_12  = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    typedef enum logic {
        ST_EXEC = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/cond_check.sv
// Condition-code evaluation: cond field against stored {N,Z,C,V}; purely
// combinational, zero latency.
module cond_check
    import control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Decoder/sequencer for the single-cycle ARM-subset core: combinational strobes, NZCV register,
// PC stalled while a load/store waits on mem_ready; CTRL_MEM_TIMEOUT_EN adds a timeout abort.
module control_unit
    import control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       alu_src,
    output logic       mem_req,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src,
    output logic [1:0] alu_control,
    output logic       undef,
    output logic       mem_err
);

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex;
    logic       dp_valid, dp_writes, is_ldr, is_str, is_br;
    logic       pc_en_c, pc_src_c, reg_write_c, mem_write_c, mem_req_c;

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       mem_err_q, mem_err_d;
`endif

    cond_check u_cond_check (
        .cond    (cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    always_comb begin
        alu_src     = 1'b0;
        imm_src     = IMM_8;
        reg_src     = 2'b00;
        alu_control = ALU_ADD;
        mem_to_reg  = 1'b0;
        undef       = 1'b0;
        dp_valid    = 1'b0;
        dp_writes   = 1'b0;
        is_ldr      = 1'b0;
        is_str      = 1'b0;
        is_br       = 1'b0;
        case (op)
            OP_DP: begin
                alu_src   = funct[5];
                dp_valid  = 1'b1;
                dp_writes = 1'b1;
                case (funct[4:1])
                    CMD_ADD: alu_control = ALU_ADD;
                    CMD_SUB: alu_control = ALU_SUB;
                    CMD_AND: alu_control = ALU_AND;
                    CMD_ORR: alu_control = ALU_ORR;
                    CMD_CMP: begin
                        alu_control = ALU_SUB;
                        dp_writes   = 1'b0;
                    end
                    default: begin
                        dp_valid  = 1'b0;
                        dp_writes = 1'b0;
                        undef     = 1'b1;
                    end
                endcase
            end
            OP_MEM: begin
                alu_src     = 1'b1;
                imm_src     = IMM_12;
                alu_control = funct[3] ? ALU_ADD : ALU_SUB;
                is_ldr      = funct[0];
                is_str      = ~funct[0];
                mem_to_reg  = funct[0];
                reg_src[1]  = ~funct[0];
            end
            OP_BR: begin
                alu_src    = 1'b1;
                imm_src    = IMM_BR;
                reg_src[0] = 1'b1;
                is_br      = 1'b1;
            end
            default: undef = 1'b1;
        endcase
    end

    // A memory op owns the cycle from issue until mem_ready; the held
    // instruction keeps is_ldr/is_str valid throughout WAIT.
    always_comb begin
        state_d     = state_q;
        pc_en_c     = 1'b1;
        reg_write_c = cond_ex & dp_writes;
        mem_write_c = 1'b0;
        mem_req_c   = 1'b0;
`ifdef CTRL_MEM_TIMEOUT_EN
        tmo_cnt_d   = 8'd0;
        mem_err_d   = mem_err_q;
`endif
        if ((state_q == ST_WAIT) || (cond_ex && (is_ldr || is_str))) begin
            mem_req_c   = 1'b1;
            mem_write_c = is_str;
            pc_en_c     = mem_ready;
            reg_write_c = is_ldr & mem_ready;
            state_d     = mem_ready ? ST_EXEC : ST_WAIT;
`ifdef CTRL_MEM_TIMEOUT_EN
            if (!mem_ready) begin
                if ((state_q == ST_WAIT) && (tmo_cnt_q == TMO_LAST)) begin
                    mem_req_c   = 1'b0;
                    mem_write_c = 1'b0;
                    pc_en_c     = 1'b1;
                    mem_err_d   = 1'b1;
                    state_d     = ST_EXEC;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
`endif
        end
        pc_src_c = cond_ex & (is_br | (reg_write_c & (rd == 4'd15)));
    end

    // Logical ops only produce meaningful N and Z; C and V are preserved.
    always_comb begin
        flags_d = flags_q;
        if (cond_ex && dp_valid && funct[0] && pc_en_c) begin
            if ((alu_control == ALU_AND) || (alu_control == ALU_ORR)) begin
                flags_d[3:2] = alu_flags[3:2];
            end else begin
                flags_d = alu_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EXEC;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end
    assign mem_err = mem_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^MEM_TIMEOUT;
    assign mem_err        = 1'b0;
`endif

    assign pc_en     = reset & pc_en_c;
    assign pc_src    = reset & pc_src_c;
    assign reg_write = reset & reg_write_c;
    assign mem_write = reset & mem_write_c;
    assign mem_req   = reset & mem_req_c;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: decode table, hand-built stall/flag/reset sequences,
// then random instruction streams against a behavioural model.
module tb_control_unit;

    localparam int TMO = 4;
`ifdef CTRL_MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] cond, rd, alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       pc_en, pc_src, reg_write, mem_write, mem_to_reg, alu_src, mem_req, undef, mem_err;
    logic [1:0] imm_src, reg_src, alu_control;
    logic [13:0] outv;

    control_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .mem_ready(mem_ready), .pc_en(pc_en), .pc_src(pc_src),
        .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .mem_req(mem_req), .imm_src(imm_src), .reg_src(reg_src),
        .alu_control(alu_control), .undef(undef), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    assign outv = {pc_en, pc_src, reg_write, mem_write, mem_to_reg, alu_src, mem_req,
                   imm_src, reg_src, alu_control, undef};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] e(int pe, int ps, int rw, int mw, int m2r, int as, int rq,
                                      int im, int rs, int al, int un);
        return {pe[0], ps[0], rw[0], mw[0], m2r[0], as[0], rq[0], im[1:0], rs[1:0], al[1:0], un[0]};
    endfunction

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r);
        cond = c; op = o; funct = f; rd = r;
    endtask

    // Reads the stored flags through conditional branches: MI, EQ, CS, VS.
    task automatic probe_flags(output logic [3:0] f);
        op = 2'b10; funct = 6'd0; rd = 4'd0;
        cond = 4'h4; #1 f[3] = pc_src;
        cond = 4'h0; #1 f[2] = pc_src;
        cond = 4'h2; #1 f[1] = pc_src;
        cond = 4'h6; #1 f[0] = pc_src;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[18];

    // Behavioural reference state
    logic [3:0] m_flags;
    bit         m_wait, m_err;
    int         m_elapsed;

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, t;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: t = z;
            3'd1: t = cy;
            3'd2: t = n;
            3'd3: t = v;
            3'd4: t = cy && !z;
            3'd5: t = (n == v);
            3'd6: t = !z && (n == v);
            default: t = 1'b1;
        endcase
        return c[0] ? !t : t;
    endfunction

    task automatic model_cycle(output logic [13:0] ex);
        int  im, rs, al;
        bit  as, m2r, und, writes, is_mem, is_ld, is_br, logic_op, sets;
        bit  ce, active, tmo, rq, mw, pe, rw, ps;
        im = 0; rs = 0; al = 0; as = 0; m2r = 0; und = 0; writes = 0;
        is_mem = 0; is_ld = 0; is_br = 0; logic_op = 0; sets = 0;
        ce = cond_true(cond, m_flags);
        if (op == 2'd0) begin
            as = funct[5];
            case (int'(funct[4:1]))
                4:  begin al = 0; writes = 1; end
                2:  begin al = 1; writes = 1; end
                0:  begin al = 2; writes = 1; logic_op = 1; end
                12: begin al = 3; writes = 1; logic_op = 1; end
                10: begin al = 1; end
                default: und = 1;
            endcase
            sets = funct[0] && !und;
        end else if (op == 2'd1) begin
            as = 1; im = 1; al = funct[3] ? 0 : 1; is_mem = 1;
            is_ld = funct[0]; m2r = funct[0]; rs = funct[0] ? 0 : 2;
        end else if (op == 2'd2) begin
            as = 1; im = 2; rs = 1; is_br = 1;
        end else begin
            und = 1;
        end
        active = is_mem && (m_wait || ce);
        tmo = TMO_EN && m_wait && !mem_ready && (m_elapsed + 1 >= TMO);
        if (active && !tmo) begin
            rq = 1; mw = !is_ld; pe = mem_ready; rw = is_ld && mem_ready;
        end else begin
            rq = 0; mw = 0; pe = 1; rw = !tmo && ce && writes;
        end
        ps = ce && (is_br || (rw && rd == 4'd15));
        ex = e(pe, ps, rw, mw, m2r, as, rq, im, rs, al, und);
        if (ce && sets && pe)
            m_flags = logic_op ? {alu_flags[3:2], m_flags[1:0]} : alu_flags;
        if (tmo) m_err = 1;
        m_wait    = active && !mem_ready && !tmo;
        m_elapsed = m_wait ? m_elapsed + 1 : 0;
    endtask

    initial begin
        logic [3:0]  f;
        logic [13:0] ex;

        vecs[0]  = '{"add",      4'hE, 2'd0, 6'b001000, 4'd1,  e(1,0,1,0,0,0,0,0,0,0,0)};
        vecs[1]  = '{"sub_imm",  4'hE, 2'd0, 6'b100100, 4'd2,  e(1,0,1,0,0,1,0,0,0,1,0)};
        vecs[2]  = '{"and",      4'hE, 2'd0, 6'b000000, 4'd3,  e(1,0,1,0,0,0,0,0,0,2,0)};
        vecs[3]  = '{"orr",      4'hE, 2'd0, 6'b011000, 4'd4,  e(1,0,1,0,0,0,0,0,0,3,0)};
        vecs[4]  = '{"cmps",     4'hE, 2'd0, 6'b010101, 4'd5,  e(1,0,0,0,0,0,0,0,0,1,0)};
        vecs[5]  = '{"add_pc",   4'hE, 2'd0, 6'b001000, 4'd15, e(1,1,1,0,0,0,0,0,0,0,0)};
        vecs[6]  = '{"ldr",      4'hE, 2'd1, 6'b011001, 4'd2,  e(1,0,1,0,1,1,1,1,0,0,0)};
        vecs[7]  = '{"str_sub",  4'hE, 2'd1, 6'b010000, 4'd2,  e(1,0,0,1,0,1,1,1,2,1,0)};
        vecs[8]  = '{"b",        4'hE, 2'd2, 6'b000000, 4'd0,  e(1,1,0,0,0,1,0,2,1,0,0)};
        vecs[9]  = '{"beq_nz",   4'h0, 2'd2, 6'b000000, 4'd0,  e(1,0,0,0,0,1,0,2,1,0,0)};
        vecs[10] = '{"op11",     4'hE, 2'd3, 6'b111111, 4'd15, e(1,0,0,0,0,0,0,0,0,0,1)};
        vecs[11] = '{"nv_add",   4'hF, 2'd0, 6'b001000, 4'd15, e(1,0,0,0,0,0,0,0,0,0,0)};
        vecs[12] = '{"bad_cmd",  4'hE, 2'd0, 6'b001100, 4'd1,  e(1,0,0,0,0,0,0,0,0,0,1)};
        vecs[13] = '{"ne_pc",    4'h1, 2'd0, 6'b001000, 4'd15, e(1,1,1,0,0,0,0,0,0,0,0)};
        vecs[14] = '{"ldr_pc",   4'hE, 2'd1, 6'b011001, 4'd15, e(1,1,1,0,1,1,1,1,0,0,0)};
        vecs[15] = '{"ldreq_no", 4'h0, 2'd1, 6'b011001, 4'd2,  e(1,0,0,0,1,1,0,1,0,0,0)};
        vecs[16] = '{"bgt",      4'hC, 2'd2, 6'b000000, 4'd0,  e(1,1,0,0,0,1,0,2,1,0,0)};
        vecs[17] = '{"blt",      4'hB, 2'd2, 6'b000000, 4'd0,  e(1,0,0,0,0,1,0,2,1,0,0)};

        reset = 1'b0; alu_flags = 4'd0; mem_ready = 1'b1;
        set_instr(4'hE, 2'd0, 6'b001000, 4'd15);
        #1;
        check("rst_pc_en", pc_en, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_pc_src", pc_src, 0);
        check("rst_mem_err", mem_err, 0);
        set_instr(4'hE, 2'd1, 6'b010000, 4'd1);
        #1;
        check("rst_mem_req", {mem_req, mem_write}, 0);
        @(negedge clk); reset = 1'b1;

        // Decode table: flags are 0000, alu_flags 0 so no edge changes state.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            set_instr(vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rd);
            #1 check(vecs[i].name, outv, vecs[i].exp);
        end

        // BEQ before and after ADDS sets Z
        @(negedge clk); set_instr(4'h0, 2'd2, 6'd0, 4'd0);
        #1 check("beq_z0_pc_src", pc_src, 0);
        check("beq_imm_reg_src", {imm_src, reg_src}, 4'b1001);
        @(negedge clk); set_instr(4'hE, 2'd0, 6'b001001, 4'd1); alu_flags = 4'b0100;
        #1 check("adds_rw_alu", {reg_write, alu_control}, 3'b100);
        @(negedge clk); probe_flags(f);
        check("adds_flags", f, 4'b0100);
        set_instr(4'h0, 2'd2, 6'd0, 4'd0);
        #1 check("beq_z1_pc_src", pc_src, 1);

        // ANDS keeps C,V
        @(negedge clk); set_instr(4'hE, 2'd0, 6'b001001, 4'd1); alu_flags = 4'b0011;
        @(negedge clk); set_instr(4'hE, 2'd0, 6'b000001, 4'd1); alu_flags = 4'b0100;
        @(negedge clk); probe_flags(f);
        check("ands_flags", f, 4'b0111);
        // ADDSNE with Z set: condition fails, no flag update
        set_instr(4'h1, 2'd0, 6'b001001, 4'd1); alu_flags = 4'b1000;
        #1 check("addsne_rw", reg_write, 0);
        @(negedge clk); probe_flags(f);
        check("addsne_flags", f, 4'b0111);

        // LDR with three wait cycles
        @(negedge clk); set_instr(4'hE, 2'd1, 6'b011001, 4'd3); mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("ldr_wait%0d", k), {pc_en, reg_write, mem_req}, 3'b001);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1 check("ldr_done", {pc_en, reg_write, mem_req, mem_to_reg}, 4'b1111);
        @(negedge clk); set_instr(4'hE, 2'd0, 6'b001000, 4'd1); mem_ready = 1'b0;
        #1 check("after_ldr_exec", {pc_en, reg_write, mem_req}, 3'b110);

        // Reset during a STR wait
        @(negedge clk); set_instr(4'hE, 2'd1, 6'b011000, 4'd4); mem_ready = 1'b0;
        @(negedge clk);
        #1 check("str_wait", {mem_req, mem_write, pc_en}, 3'b110);
        reset = 1'b0;
        #1 check("str_rst_drop", {mem_req, mem_write, pc_en}, 3'b000);
        @(negedge clk); reset = 1'b1;
        probe_flags(f);
        check("rst_flags", f, 4'b0000);
        set_instr(4'hE, 2'd0, 6'b001000, 4'd1);
        #1 check("rst_exec", {pc_en, mem_req}, 2'b10);

`ifdef CTRL_MEM_TIMEOUT_EN
        @(negedge clk); set_instr(4'hE, 2'd1, 6'b011000, 4'd4); mem_ready = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            #1 check($sformatf("tmo_wait%0d", k), {mem_req, pc_en, mem_err}, 3'b100);
            @(negedge clk);
        end
        #1 check("tmo_abort", {mem_req, mem_write, pc_en, reg_write}, 4'b0010);
        @(negedge clk); set_instr(4'hE, 2'd0, 6'b001000, 4'd1);
        #1 check("tmo_err_set", {mem_err, pc_en}, 2'b11);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", mem_err, 1);
        reset = 1'b0;
        #1 check("tmo_err_clr", mem_err, 0);
        @(negedge clk); reset = 1'b1;
`endif

        // Random streams against the behavioural model
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        m_flags = 4'd0; m_wait = 0; m_err = 0; m_elapsed = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!m_wait) begin
                cond  = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
                op    = 2'($urandom_range(0, 3));
                funct = 6'($urandom_range(0, 63));
                rd    = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            end
            alu_flags = 4'($urandom_range(0, 15));
            mem_ready = ($urandom_range(0, 2) == 0);
            #1;
            check("rnd_mem_err", mem_err, m_err);
            model_cycle(ex);
            check($sformatf("rnd_out_%0d", n), outv, ex);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
